result_display_driver: RTL and testbench

//   Output end of the calculator datapath. Captures a signed 16-bit result and an error flag
//     on a load pulse, then converts the magnitude to BCD with a sequential double-dabble
//     (one shift per clock).

---
 rtl/calc_pkg.sv | 30 +++
 rtl/seg7_decoder.sv | 36 +++
 rtl/result_display_driver.sv | 140 ++++++++++++++
 tb/tb_result_display_driver.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator output path: FSM states and
// active-high 7-segment glyphs in {g,f,e,d,c,b,a} bit order.
package calc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_UPDATE  = 2'd2
    } state_e;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_r     = 7'h50;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Map the board polarity onto an active-high glyph.
    function automatic logic [6:0] seg_polarity(input logic [6:0] seg, input bit active_low);
        return active_low ? ~seg : seg;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// One 7-segment digit decoder (active-high output). blank wins over
// everything; with err_char set, bcd 4'hE selects 'E' and any other value 'r'.
module seg7_decoder
    import calc_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    input  logic       err_char,
    output logic [6:0] seg
);

    // Glyph selection
    always_comb begin
        seg = SEG_BLANK;
        if (blank) begin
            seg = SEG_BLANK;
        end else if (err_char) begin
            seg = (bcd == 4'hE) ? SEG_E : SEG_r;
        end else begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/result_display_driver.sv
// Captures a signed result (or an error flag), converts the magnitude to BCD
// with a one-shift-per-clock double-dabble and registers the 7-segment
// patterns, sign LED and error LED.
module result_display_driver
    import calc_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int DIGITS         = 5,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] result,
    input  logic              error_in,
    output logic              busy,
    output logic              done,
    output logic [6:0]        ONES,
    output logic [6:0]        TENS,
    output logic [6:0]        HUNDREDS,
    output logic [6:0]        THOUSAND,
    output logic [6:0]        TEN_THOUSAND,
    output logic              sign,
    output logic              ERROR
);

    localparam int DD_W  = 4 * DIGITS + DATA_W;
    localparam int CNT_W = $clog2(DATA_W);

    state_e               state_q, state_d;
    logic [DD_W-1:0]      dd_q, dd_adj;
    logic [CNT_W-1:0]     cnt_q;
    logic                 neg_q, err_q;
    logic                 done_q, sign_q, error_q;
    logic [6:0]           seg_q [DIGITS];
    logic [6:0]           seg_d [DIGITS];
    logic [DATA_W-1:0]    mag;
    logic [4*DIGITS-1:0]  bcd;

    // |result| as unsigned; 16'h8000 maps to 32768 naturally
    assign mag = result[DATA_W-1] ? (~result + {{(DATA_W-1){1'b0}}, 1'b1}) : result;
    assign bcd = dd_q[DD_W-1:DATA_W];

    // Add-3 correction on every BCD nibble before the shift
    assign dd_adj[DATA_W-1:0] = dd_q[DATA_W-1:0];
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        logic [3:0] nib;
        assign nib = dd_q[DATA_W + 4*gi +: 4];
        assign dd_adj[DATA_W + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end

    // Per-digit decoders: numeric with leading-zero blanking, or the "_Err_" pattern
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
        logic       dig_blank, dig_err;
        logic [3:0] dig_bcd;
        logic [6:0] dig_seg;
        if (gi == 0) begin : g_ones
            assign dig_blank = err_q;
        end else begin : g_upper
            assign dig_blank = err_q ? (gi == DIGITS - 1 || gi == 0)
                                     : ~(|bcd[4*DIGITS-1:4*gi]);
        end
        assign dig_err = err_q;
        assign dig_bcd = err_q ? ((gi == 3) ? 4'hE : 4'h0) : bcd[4*gi +: 4];
        seg7_decoder u_dec (
            .bcd      (dig_bcd),
            .blank    (dig_blank),
            .err_char (dig_err),
            .seg      (dig_seg)
        );
        assign seg_d[gi] = seg_polarity(dig_seg, SEG_ACTIVE_LOW);
    end

    // Next-state logic for IDLE -> CONVERT -> UPDATE -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (load) state_d = error_in ? ST_UPDATE : ST_CONVERT;
            ST_CONVERT: if (cnt_q == CNT_W'(DATA_W - 1)) state_d = ST_UPDATE;
            ST_UPDATE:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Capture, conversion datapath and display registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dd_q    <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            sign_q  <= 1'b0;
            error_q <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                seg_q[i] <= seg_polarity((i == 0) ? SEG_0 : SEG_BLANK, SEG_ACTIVE_LOW);
            end
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        err_q <= error_in;
                        cnt_q <= '0;
                        if (!error_in) begin
                            neg_q <= result[DATA_W-1];
                            dd_q  <= {{(4*DIGITS){1'b0}}, mag};
                        end
                    end
                end
                ST_CONVERT: begin
                    dd_q  <= {dd_adj[DD_W-2:0], 1'b0};
                    cnt_q <= cnt_q + 1'b1;
                end
                ST_UPDATE: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        seg_q[i] <= seg_d[i];
                    end
                    sign_q  <= neg_q && (bcd != '0) && !err_q;
                    error_q <= err_q;
                    done_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;
    assign sign         = sign_q;
    assign ERROR        = error_q;
    assign ONES         = seg_q[0];
    assign TENS         = seg_q[1];
    assign HUNDREDS     = seg_q[2];
    assign THOUSAND     = seg_q[3];
    assign TEN_THOUSAND = seg_q[4];

endmodule

// File: tb/tb_result_display_driver.sv
// Directed bench for result_display_driver with hand-computed active-low glyphs.
module tb_result_display_driver;

    localparam logic [6:0] L0 = 7'h40, L1 = 7'h79, L2 = 7'h24, L3 = 7'h30, L4 = 7'h19;
    localparam logic [6:0] L5 = 7'h12, L6 = 7'h02, L7 = 7'h78, L8 = 7'h00;
    localparam logic [6:0] LE = 7'h06, LR = 7'h2F, LB = 7'h7F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] result = '0;
    logic        error_in = 1'b0;
    logic        busy, done, sign, ERROR;
    logic [6:0]  ONES, TENS, HUNDREDS, THOUSAND, TEN_THOUSAND;

    int n_checks = 0;
    int n_pass   = 0;
    int lat;
    int dones;

    always #5 clk = ~clk;

    result_display_driver dut (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .result       (result),
        .error_in     (error_in),
        .busy         (busy),
        .done         (done),
        .ONES         (ONES),
        .TENS         (TENS),
        .HUNDREDS     (HUNDREDS),
        .THOUSAND     (THOUSAND),
        .TEN_THOUSAND (TEN_THOUSAND),
        .sign         (sign),
        .ERROR        (ERROR)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s got=%0h", tag, got);
        end else begin
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Pulse load across one rising edge (E0)
    task automatic do_load(input logic [15:0] val, input logic err);
        @(negedge clk);
        result   = val;
        error_in = err;
        load     = 1'b1;
        @(posedge clk);
        #1;
        load     = 1'b0;
        error_in = 1'b0;
    endtask

    // Count edges after E0 until done is seen; bounded
    task automatic wait_done(output int edges);
        edges = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done) return;
        end
        edges = -1;
    endtask

    task automatic check_digits(input string tag, input logic [6:0] t4, input logic [6:0] t3,
                                input logic [6:0] t2, input logic [6:0] t1, input logic [6:0] t0);
        check({tag, ".TEN_THOUSAND"}, TEN_THOUSAND, t4);
        check({tag, ".THOUSAND"}, THOUSAND, t3);
        check({tag, ".HUNDREDS"}, HUNDREDS, t2);
        check({tag, ".TENS"}, TENS, t1);
        check({tag, ".ONES"}, ONES, t0);
    endtask

    initial begin
        #12;
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.sign", sign, 0);
        check("rst.ERROR", ERROR, 0);
        check_digits("rst", LB, LB, LB, LB, L0);
        @(negedge clk);
        rst = 1'b0;

        // 12345
        do_load(16'd12345, 1'b0);
        check("t1.busy", busy, 1);
        wait_done(lat);
        check("t1.latency", lat, 17);
        check_digits("t1", L1, L2, L3, L4, L5);
        check("t1.sign", sign, 0);
        check("t1.ERROR", ERROR, 0);
        @(negedge clk);
        check("t1.done_one_cycle", done, 0);
        check("t1.busy_after", busy, 0);

        // -1
        do_load(16'hFFFF, 1'b0);
        wait_done(lat);
        check("t2.latency", lat, 17);
        check_digits("t2", LB, LB, LB, LB, L1);
        check("t2.sign", sign, 1);

        // -32768
        do_load(16'h8000, 1'b0);
        wait_done(lat);
        check_digits("t3a", L3, L2, L7, L6, L8);
        check("t3a.sign", sign, 1);

        // zero
        do_load(16'h0000, 1'b0);
        wait_done(lat);
        check_digits("t3b", LB, LB, LB, LB, L0);
        check("t3b.sign", sign, 0);

        // error
        do_load(16'hFFFF, 1'b1);
        wait_done(lat);
        check("t4.latency_le2", (lat >= 1 && lat <= 2), 1);
        check_digits("t4", LB, LE, LR, LR, LB);
        check("t4.ERROR", ERROR, 1);
        check("t4.sign", sign, 0);
        @(negedge clk);
        check("t4.done_one_cycle", done, 0);

        // load while busy is ignored
        do_load(16'hFFF9, 1'b0);   // -7
        dones = 0;
        @(negedge clk);
        @(negedge clk);
        result = 16'd99;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("t5.done_count", dones, 1);
        check_digits("t5", LB, LB, LB, LB, L7);
        check("t5.sign", sign, 1);
        check("t5.ERROR", ERROR, 0);

        // reset mid-conversion
        do_load(16'd1000, 1'b0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("t6.busy_pre", busy, 1);
        rst = 1'b1;
        #1;
        check("t6.busy_rst", busy, 0);
        check("t6.done_rst", done, 0);
        check_digits("t6rst", LB, LB, LB, LB, L0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("t6.no_done", dones, 0);
        do_load(16'd42, 1'b0);
        wait_done(lat);
        check("t6.latency", lat, 17);
        check_digits("t6", LB, LB, LB, L4, L2);
        check("t6.sign", sign, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
